// File: rtl/irrigation_pkg.sv
// irrigation_pkg: shared types and constants for the irrigation timer.
//   state_t      - controller states
//   TIMER_W      - width of the watering countdown / display value
//   TICK_DIV_DEF - default clock cycles per timer unit
package irrigation_pkg;
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int TIMER_W      = 4;
   localparam int TICK_DIV_DEF = 50_000_000;
endpackage

// File: rtl/irrigation_timer_ctrl_prescaler.sv
// tick_prescaler: free-running 0..TICK_DIV-1 counter with hold and clear.
//   clk, rst - clock, synchronous active-high reset
//   en       - advance the counter (wraps at TICK_DIV-1)
//   clr      - force the counter to 0 (wins over en)
//   tick     - high while the registered counter equals TICK_DIV-1
module tick_prescaler #(
   parameter int TICK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);
   localparam int W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

   logic [W-1:0] cnt;

   assign tick = (cnt == LAST);

   always_ff @(posedge clk) begin
      if (rst || clr)
         cnt <= '0;
      else if (en)
         cnt <= tick ? '0 : cnt + W'(1);
   end
endmodule

// File: rtl/irrigation_timer_ctrl.sv
// irrigation_timer_ctrl: one irrigation cycle sequencer.
//   start          - one-cycle request to begin watering
//   pause          - level, suspends the run (valve closed, time frozen)
//   abort/soil_wet - cancel the run; soil_wet also blocks a start
//   duration       - watering time in timer units
//   valve_en/busy/done - registered status / valve drive
//   bin_number     - remaining time (previews duration while idle)
module irrigation_timer_ctrl
   import irrigation_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               pause,
   input  logic               abort,
   input  logic               soil_wet,
   input  logic [TIMER_W-1:0] duration,
   output logic               valve_en,
   output logic               busy,
   output logic               done,
   output logic [TIMER_W-1:0] bin_number
);
   state_t             state, state_nx;
   logic [TIMER_W-1:0] count, count_nx;
   logic               presc_en, presc_clr, tick;

   tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
      .clk  (clk),
      .rst  (rst),
      .en   (presc_en),
      .clr  (presc_clr),
      .tick (tick)
   );

   always_comb begin
      state_nx  = state;
      count_nx  = count;
      presc_en  = 1'b0;
      presc_clr = 1'b0;
      case (state)
         ST_IDLE: begin
            count_nx = duration;
            if (start && (duration != '0) && !soil_wet) begin
               state_nx  = ST_RUN;
               presc_clr = 1'b1;
            end
         end
         ST_RUN: begin
            if (abort || soil_wet) begin
               state_nx  = ST_IDLE;
               presc_clr = 1'b1;
            end else if (pause) begin
               // The pause-sampled cycle still has the valve open, so it
               // counts as run time; but a tick landing here is held so it
               // fires on resume instead of being lost.
               state_nx = ST_PAUSE;
               presc_en = !tick;
            end else begin
               presc_en = 1'b1;
               if (tick) begin
                  if (count == TIMER_W'(1)) begin
                     count_nx = '0;
                     state_nx = ST_DONE;
                  end else begin
                     count_nx = count - TIMER_W'(1);
                  end
               end
            end
         end
         ST_PAUSE: begin
            if (abort || soil_wet) begin
               state_nx  = ST_IDLE;
               presc_clr = 1'b1;
            end else if (!pause) begin
               state_nx = ST_RUN;
            end
         end
         default: state_nx = ST_IDLE;  // DONE: one cycle, count stays 0
      endcase
   end

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         count    <= '0;
         valve_en <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_nx;
         count    <= count_nx;
         valve_en <= (state_nx == ST_RUN);
         busy     <= (state_nx == ST_RUN) || (state_nx == ST_PAUSE);
         done     <= (state_nx == ST_DONE);
      end
   end

   assign bin_number = count;
endmodule

// File: tb/tb_irrigation_timer_ctrl.sv
module tb_irrigation_timer_ctrl;
   localparam int TD = 4;

   logic       clk = 1'b0;
   logic       rst, start, pause, abort, soil_wet;
   logic [3:0] duration;
   logic       valve_en, busy, done;
   logic [3:0] bin_number;

   int n_chk = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   irrigation_timer_ctrl #(.TICK_DIV(TD)) dut (
      .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort),
      .soil_wet(soil_wet), .duration(duration), .valve_en(valve_en),
      .busy(busy), .done(done), .bin_number(bin_number)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: elapsed valve-open run cycles against duration*TD.
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
   int mode = M_IDLE;
   int m_dur = 0, m_e = 0, m_bin = 0;

   always @(posedge clk) begin
      if (rst) begin
         mode = M_IDLE; m_bin = 0; m_e = 0;
      end else begin
         case (mode)
            M_IDLE: begin
               m_bin = duration;
               if (start && duration != 0 && !soil_wet) begin
                  mode = M_RUN; m_dur = duration; m_e = 0;
               end
            end
            M_RUN: begin
               if (abort || soil_wet) mode = M_IDLE;
               else if (pause) begin
                  mode = M_PAUSE;
                  if ((m_e + 1) % TD != 0) m_e++;
               end else begin
                  m_e++;
                  if (m_e == m_dur * TD) begin mode = M_DONE; m_bin = 0; end
                  else m_bin = m_dur - m_e / TD;
               end
            end
            M_PAUSE: begin
               if (abort || soil_wet) mode = M_IDLE;
               else if (!pause) mode = M_RUN;
            end
            default: mode = M_IDLE;
         endcase
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model valve_en", valve_en, mode == M_RUN);
         chk("model busy", busy, mode == M_RUN || mode == M_PAUSE);
         chk("model done", done, mode == M_DONE);
         chk("model bin_number", bin_number, m_bin);
      end
   end

   task automatic idle_cycles(input int n);
      start = 0; pause = 0; abort = 0; soil_wet = 0; rst = 0;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int von;
      rst = 1; start = 0; pause = 0; abort = 0; soil_wet = 0; duration = 4'd5;
      @(negedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      chk("reset valve_en", valve_en, 0);
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset bin_number", bin_number, 0);
      rst = 0;
      idle_cycles(2);
      chk("idle preview", bin_number, 5);

      // Normal run, duration 3; start again at 3 and duration change at 6
      duration = 4'd3;
      for (int i = 0; i <= 14; i++) begin
         int c;
         start = (i == 0) || (i == 3);
         if (i == 6) duration = 4'd9;
         @(posedge clk); @(negedge clk);
         c = i + 1;
         chk($sformatf("run valve c%0d", c), valve_en, c <= 12);
         chk($sformatf("run done c%0d", c), done, c == 13);
         chk($sformatf("run bin c%0d", c), bin_number,
             c <= 4 ? 3 : c <= 8 ? 2 : c <= 12 ? 1 : c <= 14 ? 0 : 9);
      end
      idle_cycles(2);

      // Pause sampled at cycles 2..7
      duration = 4'd3; von = 0;
      for (int i = 0; i <= 19; i++) begin
         int c;
         start = (i == 0);
         pause = (i >= 2 && i <= 7);
         @(posedge clk); @(negedge clk);
         c = i + 1;
         von += valve_en;
         if (c >= 3 && c <= 8) chk($sformatf("pause valve c%0d", c), valve_en, 0);
         chk($sformatf("pause busy c%0d", c), busy, c <= 18);
         chk($sformatf("pause done c%0d", c), done, c == 19);
      end
      chk("pause valve-on cycles", von, 12);
      idle_cycles(2);

      // Abort at cycle 6, duration change at 4 ignored
      duration = 4'd5;
      for (int i = 0; i <= 9; i++) begin
         int c;
         start = (i == 0);
         abort = (i == 6);
         if (i == 4) duration = 4'd7;
         @(posedge clk); @(negedge clk);
         c = i + 1;
         chk($sformatf("abort valve c%0d", c), valve_en, c <= 6);
         chk($sformatf("abort done c%0d", c), done, 0);
         if (c == 7) chk("abort bin hold", bin_number, 4);
         if (c >= 8) chk($sformatf("abort bin track c%0d", c), bin_number, 7);
      end
      idle_cycles(2);

      // Blocked starts
      duration = 4'd0; start = 1;
      @(negedge clk); start = 0;
      repeat (2) @(negedge clk);
      chk("start dur0 busy", busy, 0);
      duration = 4'd4; soil_wet = 1; start = 1;
      @(negedge clk); start = 0;
      repeat (2) @(negedge clk);
      chk("start wet valve", valve_en, 0);
      soil_wet = 0;

      // soil_wet rising mid-run
      for (int i = 0; i <= 6; i++) begin
         int c;
         start = (i == 0);
         soil_wet = (i == 5);
         @(posedge clk); @(negedge clk);
         c = i + 1;
         chk($sformatf("wet valve c%0d", c), valve_en, c <= 5);
         chk($sformatf("wet busy c%0d", c), busy, c <= 5);
         if (c == 6) chk("wet bin hold", bin_number, 3);
         if (c == 7) chk("wet bin track", bin_number, 4);
      end
      idle_cycles(2);

      // Reset mid-run at cycle 7
      duration = 4'd6;
      for (int i = 0; i <= 8; i++) begin
         int c;
         start = (i == 0);
         rst = (i == 7);
         @(posedge clk); @(negedge clk);
         c = i + 1;
         if (c == 8) begin
            chk("rst valve", valve_en, 0);
            chk("rst busy", busy, 0);
            chk("rst done", done, 0);
            chk("rst bin", bin_number, 0);
         end
         if (c == 9) chk("rst bin track", bin_number, 6);
      end
      idle_cycles(2);

      // start with abort in IDLE: abort ignored
      duration = 4'd2;
      for (int i = 0; i <= 9; i++) begin
         int c;
         start = (i == 0);
         abort = (i == 0);
         @(posedge clk); @(negedge clk);
         c = i + 1;
         chk($sformatf("sa valve c%0d", c), valve_en, c <= 8);
         chk($sformatf("sa done c%0d", c), done, c == 9);
      end
      idle_cycles(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
